// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline slice: adds chunk INDEX of the operands and registers carry, valid and data.
// Optional signed-overflow output when PIPELINED_ADDER_OVF_EN is defined.
module adder_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int INDEX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic             valid_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int LO = INDEX * CHUNK;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    chunk_sum = {1'b0, a_in[LO +: CHUNK]} + {1'b0, b_in[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_in};
    sum_next  = sum_in;
    sum_next[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Full-width operand/sum registers keep every slice identical; bits that are
  // never read downstream are trimmed by synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      carry_out <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      sum_out   <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      carry_out <= chunk_sum[CHUNK];
      a_out     <= a_in;
      b_out     <= b_in;
      sum_out   <= sum_next;
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic msb_carry_in;

  assign msb_carry_in = chunk_sum[CHUNK-1] ^ a_in[LO+CHUNK-1] ^ b_in[LO+CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ovf_out <= 1'b0;
    else if (en) ovf_out <= msb_carry_in ^ chunk_sum[CHUNK];
  end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-pipelined adder with valid/ready handshake and global stall.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic                          advance;
  logic [STAGES:0]               v_p;
  logic [STAGES:0]               c_p;
  logic [STAGES:0][WIDTH-1:0]    a_p;
  logic [STAGES:0][WIDTH-1:0]    b_p;
  logic [STAGES:0][WIDTH-1:0]    s_p;
`ifdef PIPELINED_ADDER_OVF_EN
  logic [STAGES:1]               ovf_p;
`endif
  logic                          unused_tail;

  // Single stall signal: the whole pipe moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign v_p[0] = in_valid;
  assign c_p[0] = cin;
  assign a_p[0] = a;
  assign b_p[0] = b;
  assign s_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .INDEX (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .valid_in  (v_p[k]),
      .carry_in  (c_p[k]),
      .a_in      (a_p[k]),
      .b_in      (b_p[k]),
      .sum_in    (s_p[k]),
      .valid_out (v_p[k+1]),
      .carry_out (c_p[k+1]),
      .a_out     (a_p[k+1]),
      .b_out     (b_p[k+1]),
      .sum_out   (s_p[k+1])
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf_out   (ovf_p[k+1])
`endif
    );
  end

  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf         = ovf_p[STAGES];
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES], ovf_p};
`else
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};
`endif

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0 and STAGES >= 1 are required. Illegal values SHALL stop elaboration.
REQ-003 SHALL expose: clk  input  1  single clock, rising edge.
REQ-004 SHALL expose: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL expose: in_valid  input  1  operand beat present.
REQ-006 SHALL expose: in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL expose: a, b  input  WIDTH  operands, unsigned, or two's complement under REQ-024.
REQ-008 SHALL expose: cin  input  1  carry-in.
REQ-009 SHALL expose: out_valid  output  1  result present.
REQ-010 SHALL expose: out_ready  input  1  downstream accepts result.
REQ-011 SHALL expose: sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
REQ-012 SHALL expose: cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL split operands into STAGES chunks of CHUNK = WIDTH/STAGES bits. Stage k adds chunk k plus the registered carry from stage k-1. Stage 0 uses cin.
REQ-014 SHALL delay the upper, not-yet-added operand chunks and the already-computed lower sum chunks alongside each stage, so every beat exits fully aligned.
REQ-015 SHALL accept a beat on clk when in_valid && in_ready, and deliver a result on clk when out_valid && out_ready.
REQ-016 SHALL use a global advance = !out_valid || out_ready. in_ready SHALL equal advance, combinationally. All stage registers and per-stage valid bits SHALL load only when advance is high.
REQ-017 SHALL give latency of exactly STAGES cycles from acceptance to out_valid, with out_ready held high. Throughput SHALL be one beat per cycle.
REQ-018 SHALL keep bubbles in place: an invalid stage advances as a bubble and is not compressed.
REQ-019 SHALL hold sum, cout and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL handle a simultaneous accept and deliver in one cycle (full pipe, out_ready=1, in_valid=1) with no loss and no duplication.
REQ-021 SHALL deliver results in acceptance order.
REQ-022 SHALL give results whose sum/cout are bit-identical to a single-cycle (WIDTH+1)-bit addition.

Reset
REQ-023 SHALL, while rst_n=0, clear all stage valid bits, out_valid, sum, cout (and ovf) to 0, and hold in_ready=1. Beats in flight when reset asserts SHALL be discarded. The first accept SHALL occur on the first clk edge after deassert.

Configuration
REQ-024 SHALL honour macro PIPELINED_ADDER_OVF_EN. When defined: add port ovf  output  1, the signed overflow of the final stage (carry into MSB XOR carry out of MSB), aligned with sum, reset 0. When undefined: no ovf port and no associated logic.

Structure
REQ-025 SHALL place in shared package pipelined_adder_pkg: default WIDTH/STAGES constants and a function computing CHUNK.
REQ-026 SHALL use one sub-module, adder_stage: a CHUNK-bit adder plus carry/valid/data register slice with an enable input, instantiated STAGES times via generate.

Verification (WIDTH=16, STAGES=4)
REQ-027 Carry ripple: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, out_valid=1 for one cycle.
REQ-028 Streaming: 8 back-to-back beats (a=i, b=0x1000*i, cin=i[0]) -> 8 consecutive results, in order, all matching the reference model, first at cycle 4.
REQ-029 Backpressure: fill the pipe, then out_ready=0 for 5 cycles -> in_ready=0 and sum/cout held constant. Release -> no beat lost or duplicated.
REQ-030 Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately. After release, no stale result ever appears.
REQ-031 Overflow (macro defined): a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. a=0xFFFF, b=0x0001 -> ovf=0, cout=1.
REQ-032 Parameter sweep: STAGES in {1,2,8,16} with 10k random beats and random out_ready -> scoreboard exact match.
